// File: rtl/matrix_pkg.sv
// Shared constants, FSM encoding and width helpers for the matrix UART printer.
package matrix_pkg;

    localparam logic [7:0] AsciiZero  = 8'h30;
    localparam logic [7:0] AsciiSpace = 8'h20;
    localparam logic [7:0] AsciiLf    = 8'h0A;
    localparam logic [7:0] AsciiMinus = 8'h2D;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StConv,
        StEmit,
        StWaitHi,
        StWaitLo,
        StNext,
        StDone
    } state_e;

    // Width needed to hold a row/column count in 0..max_dim.
    function automatic int unsigned dim_w(input int unsigned max_dim);
        return $clog2(max_dim + 1);
    endfunction

    // Decimal digits needed for the largest unsigned value of the given width.
    function automatic int unsigned dec_digits(input int unsigned width);
        longint unsigned max_val;
        longint unsigned pow;
        int unsigned     n;
        max_val = (64'd1 << width) - 64'd1;
        pow     = 64'd10;
        n       = 1;
        while (pow <= max_val && n < 19) begin
            pow = pow * 64'd10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/matrix_uart_printer_if.sv
// Byte-strobe handshake between the printer and a UART transmitter.
interface matrix_uart_printer_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/bin2dec_seq.sv
// Sequential double-dabble binary to BCD converter; done pulses DATA_W cycles after start.
module bin2dec_seq
    import matrix_pkg::*;
#(
    parameter  int unsigned DATA_W = 9,
    localparam int unsigned NDIG   = dec_digits(DATA_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   bin,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd,
    output logic [7:0]          nd
);
    localparam int unsigned CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_q;
    logic [4*NDIG-1:0] bcd_q;
    logic [4*NDIG-1:0] bcd_adj;
    logic [CW-1:0]     cnt_q;
    logic              run_q;
    logic              done_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                shift_q <= bin;
                bcd_q   <= '0;
                cnt_q   <= CW'(DATA_W);
                run_q   <= 1'b1;
            end else if (run_q) begin
                {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                cnt_q            <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Digit count ignores leading zeros but never drops below one.
    always_comb begin
        nd = 8'd1;
        for (int i = 1; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) nd = 8'(i + 1);
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/matrix_uart_printer.sv
// Prints a row-major matrix as padded decimal fields over a byte-strobe UART.
// Define MATRIX_PRINT_SIGNED_EN to print elements as two's complement values.
module matrix_uart_printer
    import matrix_pkg::*;
#(
    parameter  int unsigned DATA_W  = 9,
    parameter  int unsigned MAX_DIM = 5,
    parameter  int unsigned FIELD_W = 3,
    localparam int unsigned DW      = dim_w(MAX_DIM)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                align_right,
    input  logic [DW-1:0]                       matrix_row,
    input  logic [DW-1:0]                       matrix_col,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   data_flat,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    matrix_uart_printer_if.master               tx
);
    localparam int unsigned NELEM = MAX_DIM * MAX_DIM;
    localparam int unsigned KW    = 2 * DW;
    localparam int unsigned NDIG  = dec_digits(DATA_W);

    state_e                     state_q, state_d;
    logic                       start_q;
    logic                       align_q;
    logic [DW-1:0]              row_q, col_q;
    logic [NELEM*DATA_W-1:0]    data_q;
    logic [DW-1:0]              r_q, r_d, c_q, c_d;
    logic [7:0]                 pos_q, pos_d;
    logic [1:0]                 tmo_q, tmo_d;

    logic                       start_rise;
    logic                       dim_bad;
    logic                       last_col;
    logic [KW-1:0]              k;
    logic [DATA_W-1:0]          elem;
    logic [DATA_W-1:0]          mag;
    logic                       elem_neg;
    logic                       b2d_start;
    logic                       b2d_done;
    logic [4*NDIG-1:0]          bcd;
    logic [7:0]                 nd;
    logic [7:0]                 len, pad, total, ci, di;
    logic [3:0]                 digit;
    logic [7:0]                 cur_byte;

    assign start_rise = start & ~start_q;
    assign dim_bad    = (row_q == '0) || (col_q == '0) ||
                        (row_q > DW'(MAX_DIM)) || (col_q > DW'(MAX_DIM));
    assign last_col   = (c_q == col_q - DW'(1));
    assign k          = KW'(r_q) * KW'(col_q) + KW'(c_q);

    always_comb begin
        elem = '0;
        for (int i = 0; i < NELEM; i++) begin
            if (k == KW'(i)) elem = data_q[i*DATA_W +: DATA_W];
        end
    end

    // r/c stay fixed while an element is emitted, so the sign can be read live.
`ifdef MATRIX_PRINT_SIGNED_EN
    assign elem_neg = elem[DATA_W-1];
    assign mag      = elem_neg ? (~elem + DATA_W'(1)) : elem;
`else
    assign elem_neg = 1'b0;
    assign mag      = elem;
`endif

    bin2dec_seq #(
        .DATA_W (DATA_W)
    ) u_bin2dec (
        .clk   (clk),
        .rst_n (rst_n),
        .start (b2d_start),
        .bin   (mag),
        .done  (b2d_done),
        .bcd   (bcd),
        .nd    (nd)
    );

    // Field layout: [pad][sign][digits] or [sign][digits][pad], then one separator.
    always_comb begin
        len   = nd + {7'd0, elem_neg};
        pad   = (len < 8'(FIELD_W)) ? 8'(FIELD_W) - len : 8'd0;
        total = pad + len + 8'd1;
        ci    = align_q ? pos_q - pad : pos_q;
        di    = nd - 8'd1 - (ci - {7'd0, elem_neg});
        digit = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (di == 8'(i)) digit = bcd[4*i +: 4];
        end
        if (pos_q == total - 8'd1) begin
            cur_byte = last_col ? AsciiLf : AsciiSpace;
        end else if (align_q ? (pos_q < pad) : (pos_q >= len)) begin
            cur_byte = AsciiSpace;
        end else if (elem_neg && ci == 8'd0) begin
            cur_byte = AsciiMinus;
        end else begin
            cur_byte = AsciiZero + {4'd0, digit};
        end
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        pos_d     = pos_q;
        tmo_d     = tmo_q;
        b2d_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    r_d     = '0;
                    c_d     = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (dim_bad) begin
                    state_d = StDone;
                end else begin
                    b2d_start = 1'b1;
                    state_d   = StConv;
                end
            end
            StConv: begin
                if (b2d_done) begin
                    pos_d   = '0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (!tx.tx_busy) begin
                    tmo_d   = '0;
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                // A transmitter that never raises busy is treated as having taken the byte.
                if (tx.tx_busy || tmo_q == 2'd3) state_d = StWaitLo;
                else                             tmo_d   = tmo_q + 2'd1;
            end
            StWaitLo: begin
                if (!tx.tx_busy) begin
                    if (pos_q == total - 8'd1) begin
                        state_d = StNext;
                    end else begin
                        pos_d   = pos_q + 8'd1;
                        state_d = StEmit;
                    end
                end
            end
            StNext: begin
                if (last_col) begin
                    c_d = '0;
                    if (r_q == row_q - DW'(1)) begin
                        state_d = StDone;
                    end else begin
                        r_d     = r_q + DW'(1);
                        state_d = StLoad;
                    end
                end else begin
                    c_d     = c_q + DW'(1);
                    state_d = StLoad;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // start_q resets high so a start held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            start_q <= 1'b1;
            align_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            r_q     <= '0;
            c_q     <= '0;
            pos_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            r_q     <= r_d;
            c_q     <= c_d;
            pos_q   <= pos_d;
            tmo_q   <= tmo_d;
            if (state_q == StIdle && start_rise) begin
                align_q <= align_right;
                row_q   <= matrix_row;
                col_q   <= matrix_col;
                data_q  <= data_flat;
            end
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign err         = done && dim_bad;
    assign tx.tx_start = (state_q == StEmit) && !tx.tx_busy;
    assign tx.tx_data  = tx.tx_start ? cur_byte : 8'h00;

endmodule

// File: tb/tb_matrix_uart_printer.sv
// Randomised self-checking bench for matrix_uart_printer with a string-based reference model.
`timescale 1ns/1ps
module tb_matrix_uart_printer;
    localparam int unsigned DATA_W  = 9;
    localparam int unsigned MAX_DIM = 5;
    localparam int unsigned FIELD_W = 3;
    localparam int unsigned DW      = $clog2(MAX_DIM + 1);
    localparam int unsigned FLAT_W  = MAX_DIM * MAX_DIM * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              align_right = 1'b0;
    logic [DW-1:0]     matrix_row = '0;
    logic [DW-1:0]     matrix_col = '0;
    logic [FLAT_W-1:0] data_flat = '0;
    logic              busy, done, err;

    matrix_uart_printer_if tx_if ();

    matrix_uart_printer #(
        .DATA_W  (DATA_W),
        .MAX_DIM (MAX_DIM),
        .FIELD_W (FIELD_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .align_right (align_right),
        .matrix_row  (matrix_row),
        .matrix_col  (matrix_col),
        .data_flat   (data_flat),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .tx          (tx_if.master)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    byte unsigned got_q[$];
    byte unsigned exp_q[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          strobe_cnt = 0;
    int          strobe_while_busy = 0;
    int          uart_hold = 2;
    int          hold_cnt = 0;

    // UART stand-in: busy rises the cycle after a strobe and stays high uart_hold cycles.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (tx_if.tx_start) begin
            got_q.push_back(tx_if.tx_data);
            strobe_cnt++;
            if (tx_if.tx_busy) strobe_while_busy++;
            hold_cnt = uart_hold;
        end else if (hold_cnt > 0) begin
            tx_if.tx_busy = 1'b1;
            hold_cnt--;
        end else begin
            tx_if.tx_busy = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_elem(input int k, input int v);
        data_flat[k*DATA_W +: DATA_W] = DATA_W'(v);
    endtask

    task automatic exp_from_str(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Reference model: format each element with $sformatf and plain string padding.
    task automatic build_exp(input int rows, input int cols, input bit align,
                             input logic [FLAT_W-1:0] flat);
        logic [FLAT_W-1:0] tmp;
        int                v;
        bit                neg;
        string             s;
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                tmp = flat >> ((r * cols + c) * DATA_W);
                v   = int'(tmp[DATA_W-1:0]);
                neg = 1'b0;
`ifdef MATRIX_PRINT_SIGNED_EN
                if (v >= (1 << (DATA_W - 1))) begin
                    neg = 1'b1;
                    v   = (1 << DATA_W) - v;
                end
`endif
                s = $sformatf("%0d", v);
                if (neg) s = {"-", s};
                while (s.len() < FIELD_W) s = align ? {" ", s} : {s, " "};
                s = {s, (c == cols - 1) ? "\n" : " "};
                for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
            end
        end
    endtask

    task automatic check_bytes(input string tag);
        check_eq({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic run_job(input int rows, input int cols, input bit align, input int hold,
                           output bit finished);
        @(negedge clk);
        uart_hold   = hold;
        matrix_row  = DW'(rows);
        matrix_col  = DW'(cols);
        align_right = align;
        got_q.delete();
        done_cnt    = 0;
        err_cnt     = 0;
        strobe_cnt  = 0;
        start       = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        finished = 1'b0;
        for (int i = 0; i < 20000 && !finished; i++) begin
            @(negedge clk);
            if (done) finished = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic job_and_check(input string tag, input int rows, input int cols,
                                 input bit align, input int hold);
        bit fin;
        run_job(rows, cols, align, hold, fin);
        check_eq({tag, " finished"}, fin, 1);
        check_bytes(tag);
        check_eq({tag, " done pulses"}, done_cnt, 1);
        check_eq({tag, " err pulses"}, err_cnt, 0);
        check_eq({tag, " busy after"}, busy, 0);
    endtask

    task automatic bad_dim(input string tag, input int rows, input int cols);
        @(negedge clk);
        matrix_row = DW'(rows);
        matrix_col = DW'(cols);
        strobe_cnt = 0;
        done_cnt   = 0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, " done early"}, done, 0);
        @(posedge clk);
        #1;
        check_eq({tag, " done"}, done, 1);
        check_eq({tag, " err"}, err, 1);
        check_eq({tag, " busy in done"}, busy, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq({tag, " busy after"}, busy, 0);
        check_eq({tag, " strobes"}, strobe_cnt, 0);
        check_eq({tag, " done pulses"}, done_cnt, 1);
    endtask

    initial begin
        bit fin;
        logic [FLAT_W-1:0] saved;
        int rows, cols;

        repeat (3) @(negedge clk);
        check_eq("rst busy", busy, 0);
        check_eq("rst done", done, 0);
        check_eq("rst err", err, 0);
        check_eq("rst tx_start", tx_if.tx_start, 0);
        check_eq("rst tx_data", tx_if.tx_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        data_flat = '0;
        set_elem(0, 5); set_elem(1, 123); set_elem(2, 40); set_elem(3, 0);
        exp_from_str("5   123\n40  0  \n");
        job_and_check("left2x2", 2, 2, 1'b0, 2);
        exp_from_str("  5 123\n 40   0\n");
        job_and_check("right2x2", 2, 2, 1'b1, 2);

        data_flat = '0;
        set_elem(0, 511); set_elem(1, 7); set_elem(2, 99);
`ifdef MATRIX_PRINT_SIGNED_EN
        exp_from_str("-1  7   99 \n");
`else
        exp_from_str("511 7   99 \n");
`endif
        job_and_check("row1x3", 1, 3, 1'b0, 1);

        data_flat = '0;
        for (int i = 0; i < 6; i++) set_elem(i, i + 1);
        exp_from_str("1   2   3  \n4   5   6  \n");
        job_and_check("layout2x3", 2, 3, 1'b0, 1);
        if (got_q.size() > 12) check_eq("layout r1c0 from k3", got_q[12], 8'h34);
        else check_eq("layout r1c0 present", got_q.size(), 13);

        bad_dim("row0", 0, 2);
        bad_dim("col6", 2, 6);

        // Slow UART, start re-pulsed and data changed mid-job.
        for (int i = 0; i < 4; i++) set_elem(i, int'($urandom_range(0, 511)));
        saved = data_flat;
        build_exp(2, 2, 1'b0, saved);
        strobe_while_busy = 0;
        fork
            run_job(2, 2, 1'b0, 50, fin);
            begin
                repeat (300) @(negedge clk);
                start     = 1'b1;
                data_flat = ~saved;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check_eq("slow finished", fin, 1);
        check_bytes("slow");
        check_eq("slow strobes", strobe_cnt, exp_q.size());
        check_eq("slow strobe while busy", strobe_while_busy, 0);
        check_eq("slow done pulses", done_cnt, 1);
        repeat (20) @(negedge clk);
        check_eq("slow no retrigger", strobe_cnt, exp_q.size());
        check_eq("slow idle", busy, 0);

        for (int i = 0; i < 4; i++) set_elem(i, int'($urandom_range(0, 511)));
        build_exp(2, 2, 1'b1, data_flat);
        job_and_check("timeout", 2, 2, 1'b1, 0);

        // Reset after the third byte with start held high.
        for (int i = 0; i < 9; i++) set_elem(i, int'($urandom_range(0, 511)));
        @(negedge clk);
        uart_hold  = 1;
        matrix_row = DW'(3);
        matrix_col = DW'(3);
        strobe_cnt = 0;
        done_cnt   = 0;
        start      = 1'b1;
        fin        = 1'b0;
        for (int i = 0; i < 2000 && !fin; i++) begin
            @(negedge clk);
            #1;
            if (strobe_cnt == 3) fin = 1'b1;
        end
        check_eq("rstmid third byte", fin, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid busy", busy, 0);
        check_eq("rstmid done", done, 0);
        check_eq("rstmid err", err, 0);
        check_eq("rstmid tx_start", tx_if.tx_start, 0);
        check_eq("rstmid tx_data", tx_if.tx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("rstmid bytes", strobe_cnt, 3);
        check_eq("rstmid no done", done_cnt, 0);
        check_eq("rstmid held start", busy, 0);
        start = 1'b0;
        repeat (3) @(negedge clk);

        for (int j = 0; j < 8; j++) begin
            rows = int'($urandom_range(1, MAX_DIM));
            cols = int'($urandom_range(1, MAX_DIM));
            for (int i = 0; i < MAX_DIM * MAX_DIM; i++) set_elem(i, int'($urandom_range(0, 511)));
            fin = 1'($urandom_range(0, 1));
            build_exp(rows, cols, fin, data_flat);
            job_and_check($sformatf("rand%0d", j), rows, cols, fin, int'($urandom_range(0, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_uart_printer.md
MATRIX_UART_PRINTER -- requirements
Module: matrix_uart_printer

Interface
REQ-001 SHALL have parameter DATA_W, default 9, meaning element width in bits.
REQ-002 SHALL have parameter MAX_DIM, default 5, meaning the maximum row and column count.
REQ-003 SHALL have parameter FIELD_W, default 3, meaning the minimum printed characters per element.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low, one clock.
REQ-006 SHALL have port start  input  1  print request; acts on its rising edge only.
REQ-007 SHALL have port align_right  input  1  0 = left-justified padding, 1 = right-justified; sampled at start.
REQ-008 SHALL have port matrix_row  input  DW=$clog2(MAX_DIM+1)  number of rows.
REQ-009 SHALL have port matrix_col  input  DW  number of columns.
REQ-010 SHALL have port data_flat  input  MAX_DIM*MAX_DIM*DATA_W  row-major elements; element k is at bits [k*DATA_W +: DATA_W], with k = r*matrix_col + c.
REQ-011 SHALL have port busy  output  1  high from the accepted start until done.
REQ-012 SHALL have port done  output  1  one-cycle pulse at job end.
REQ-013 SHALL have port err  output  1  one-cycle pulse, coincident with done, for an illegal dimension.
REQ-014 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-015 SHALL have port tx_start  output  1  one-cycle byte strobe.
REQ-016 SHALL have port tx_data  output  8  byte to send; valid while tx_start is high.

Function
REQ-017 SHALL accept a start rising edge only in IDLE; edges while busy are ignored, and start held high does not retrigger.
REQ-018 SHALL on acceptance snapshot data_flat, matrix_row, matrix_col and align_right into internal registers; later input changes do not affect the job.
REQ-019 SHALL, if row or col is 0 or greater than MAX_DIM, emit no bytes and pulse done and err 2 cycles after the start edge.
REQ-020 SHALL implement the states IDLE, LOAD, CONV, EMIT, WAIT_HI, WAIT_LO, NEXT and DONE:
- LOAD selects element k.
- CONV performs decimal conversion without / or % operators.
- EMIT issues one byte.
- WAIT_HI and WAIT_LO complete the byte handshake.
- NEXT advances column, then row.
- DONE pulses done and returns to IDLE.
REQ-021 SHALL compute the index k at full width (at least 2*DW bits) with no truncation before selection.
REQ-022 SHALL format each element as its ND decimal digits, with no leading zeros and ND >= 1, padded with spaces (0x20) to FIELD_W characters.
REQ-023 SHALL, when align_right is 0, place the padding spaces after the digits.
REQ-024 SHALL, when align_right is 1, place the padding spaces before the digits.
REQ-025 SHALL, when ND exceeds FIELD_W, print all digits with no padding and never truncate.
REQ-026 SHALL follow each element with a space separator, or with LF (0x0A) when c == col-1.
REQ-027 SHALL handshake each byte as follows:
- Assert tx_start for one cycle only when tx_busy is low.
- Wait in WAIT_HI for tx_busy high.
- Wait in WAIT_LO for tx_busy low.
- Only then issue the next byte.
REQ-028 SHALL, if tx_busy does not rise within 4 cycles after tx_start, treat the byte as sent and proceed.
REQ-029 SHALL keep busy high during the job, including the cycle done pulses, and drive busy low in the next cycle.
REQ-030 SHALL make the total byte count per job equal to the sum of the element field lengths plus row*col separators.

Reset
REQ-031 SHALL on rst_n low immediately force the state to IDLE and drive busy, done, err and tx_start to 0 and tx_data to 0x00.
REQ-032 SHALL on reset mid-job abandon the job with no further bytes and no done pulse, and clear the start edge detector so that start held high through reset does not trigger.

Configuration
REQ-033 SHALL, with macro MATRIX_PRINT_SIGNED_EN defined, interpret elements as two's complement.
REQ-034 SHALL, with MATRIX_PRINT_SIGNED_EN defined, print negative elements as '-' followed by the magnitude digits, with the sign counted in the field length.
REQ-035 SHALL, without MATRIX_PRINT_SIGNED_EN, interpret elements as unsigned with no sign logic synthesised.

Structure
REQ-036 SHALL place ASCII constants (0x30, 0x20, 0x0A, 0x2D), the state encoding and a width helper for MAX_DIM-derived widths in shared package matrix_pkg.
REQ-037 SHALL implement decimal conversion in sub-module bin2dec_seq using sequential double-dabble with start/done handshake, taking DATA_W + 2 cycles or fewer.

Verification
REQ-038 SHALL cover: 2x2 matrix [5,123;40,0] with FIELD_W=3, align_right=0 -> bytes "5   123 40  0  \n" with each row terminated by LF; 16 bytes; one done pulse.
REQ-039 SHALL cover: the same matrix with align_right=1 -> "  5 123  40   0\n" per row.
REQ-040 SHALL cover: 1x3 matrix with elements 511, 7, 99, with a 2x3 layout check confirming index r*col+c -> row 1 element 0 taken from k=3.
REQ-041 SHALL cover: row=0 or col=6 with MAX_DIM=5 -> zero tx_start pulses; done and err pulse together 2 cycles after start.
REQ-042 SHALL cover: tx_busy held high for 50 cycles after each strobe -> exactly one tx_start per byte; start re-pulsed mid-job is ignored; data_flat changed mid-job does not alter output.
REQ-043 SHALL cover: rst_n asserted after the third byte -> outputs 0 within the reset cycle; no further bytes; no done pulse. With MATRIX_PRINT_SIGNED_EN and DATA_W=9, element 0x1FF prints "-1 ".
